seq_store_buf: RTL and testbench
================================

SEQ_STORE_BUF -- requirements
Module: seq_store_buf

Interface
REQ-001 Parameter SEQ_W, default 10, SHALL set the width of one Morse sequence code.
REQ-002 Parameter DEPTH, default 16, SHALL set the number of stored sequence slots (DEPTH >= 2).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be asynchronous and active-high.
REQ-005 store  input  1  SHALL be the sample strobe for first_seq/sec_seq, replacing the level-sensitive sentFlag.
REQ-006 first_seq, sec_seq  input  SEQ_W each  SHALL be the candidate sequences; a lane is invalid when its two MSBs are 2'b11.
REQ-007 enter  input  1  SHALL request a snapshot and a read-out.
REQ-008 o_sequence  output  DEPTH*SEQ_W  SHALL hold the snapshot: newest entry in bits [SEQ_W-1:0], older entries in successively higher slots, unused slots all ones.
REQ-009 rd_data  output  SEQ_W; rd_valid  output  1; rd_ready  input  1; rd_last  output  1 SHALL form the read-out stream, oldest entry first.
REQ-010 count  output  $clog2(DEPTH+1)  SHALL give the number of live entries.
REQ-011 full  output  1; overflow  output  1 (sticky) SHALL flag capacity status.

Function
REQ-012 Storage SHALL be a circular buffer of DEPTH slots with a write pointer and count; no whole-vector shifting.
REQ-013 On a cycle with store=1, each valid lane SHALL be written in that cycle, first_seq before sec_seq; both valid SHALL add 2 entries in one cycle.
REQ-014 With one free slot and both lanes valid, first_seq SHALL be stored; sec_seq SHALL be handled per REQ-022/REQ-023.
REQ-015 store=1 with both lanes invalid SHALL change nothing.
REQ-016 full SHALL equal (count == DEPTH), combinationally from registered count.
REQ-017 enter=1 with FSM in IDLE SHALL update o_sequence one cycle later, including entries written in the same cycle as enter, and latch count into the stream length.
REQ-018 Read-out FSM states: IDLE, STREAM. IDLE->STREAM on enter when latched length > 0; the cycle after enter, rd_valid=1 presenting the oldest snapshot entry.
REQ-019 In STREAM, data SHALL advance only on rd_valid&&rd_ready; rd_data/rd_valid stable while rd_ready=0; rd_last=1 on the final entry; transfer of the final entry returns to IDLE with rd_valid=0.
REQ-020 enter during STREAM SHALL be ignored (no snapshot, no restart); enter with count=0 SHALL update o_sequence to all ones and stay IDLE.
REQ-021 Stores during STREAM SHALL proceed and SHALL not alter the streamed data (stream reads the snapshot).

Configuration
REQ-022 With SEQ_STORE_RING_EN defined, a write to a full buffer SHALL overwrite the oldest entry, count stays DEPTH, and overflow SHALL set.
REQ-023 Without SEQ_STORE_RING_EN, a write to a full buffer SHALL be dropped, contents unchanged, and overflow SHALL set.

Reset
REQ-024 Reset SHALL clear pointers and count, set all slots and o_sequence to all ones, rd_valid=0, rd_last=0, rd_data=all ones, overflow=0, FSM=IDLE.
REQ-025 Reset mid-STREAM SHALL abort the stream immediately (rd_valid=0 asynchronously).

Structure
REQ-026 Package morse_pkg SHALL hold SEQ_W default, the INVALID_TAG constant 2'b11 and the read-out FSM state typedef.
REQ-027 Read-out FSM with its index counter SHALL be sub-module seq_readout; the buffer and snapshot stay in seq_store_buf.

Verification (SEQ_W=10, DEPTH=16)
REQ-028 Store 10'h001/10'h002 both valid, then enter -> count=2, o_sequence[19:0]={10'h001,10'h002}, upper bits all ones.
REQ-029 Store first=10'h3FF (invalid), sec=10'h005 -> count=1, slot 0 holds 10'h005.
REQ-030 Fill 15 entries, store two valid -> first kept, count=16, full=1, overflow=1; ring build: oldest replaced, non-ring: second dropped.
REQ-031 3 entries, enter, rd_ready toggling 1,0,1,1 -> 3 transfers oldest-first, data held while stalled, rd_last on third, then IDLE.
REQ-032 During STREAM, store 2 entries and pulse enter -> stream unchanged, count=5 afterward, no restart.
REQ-033 Assert reset mid-STREAM -> rd_valid drops without a clock edge, count=0, o_sequence all ones.

Source files
------------

// File: rtl/morse_pkg.sv
// Package: morse_pkg
// Shared definitions for the Morse sequence store buffer.
//   SEQ_W_DEF    default width of one Morse sequence code
//   DEPTH_DEF    default number of stored sequence slots
//   INVALID_TAG  MSB pair that marks a lane as carrying no sequence
//   rd_state_t   read-out FSM state encoding
//   tag_ok()     lane-validity helper applied to the two MSBs of a lane
package morse_pkg;

   localparam int SEQ_W_DEF = 10;
   localparam int DEPTH_DEF = 16;

   localparam logic [1:0] INVALID_TAG = 2'b11;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } rd_state_t;

   // A lane is usable unless its two MSBs carry the invalid tag.
   function automatic logic tag_ok(input logic [1:0] tag);
      return (tag != INVALID_TAG);
   endfunction

endpackage

// File: rtl/seq_store_buf_if.sv
// Interface: seq_store_buf_if
// Read-out stream of the sequence store buffer (valid/ready handshake).
//   rd_data   sequence code being presented (master -> slave)
//   rd_valid  rd_data holds a snapshot entry (master -> slave)
//   rd_last   rd_data is the final entry of the stream (master -> slave)
//   rd_ready  consumer accepts rd_data this cycle (slave -> master)
interface seq_store_buf_if #(
   parameter int SEQ_W = morse_pkg::SEQ_W_DEF
) ();

   logic [SEQ_W-1:0] rd_data;
   logic             rd_valid;
   logic             rd_last;
   logic             rd_ready;

   modport master (
      output rd_data,
      output rd_valid,
      output rd_last,
      input  rd_ready
   );

   modport slave (
      input  rd_data,
      input  rd_valid,
      input  rd_last,
      output rd_ready
   );

endinterface

// File: rtl/seq_readout.sv
// Module: seq_readout
// Read-out FSM that streams a snapshot oldest-first over a valid/ready port.
// Snapshot slot 0 is the newest entry, so the stream walks the slot index
// downward from (length-1) to 0.
//   clk, reset  clock and asynchronous active-high reset
//   enter       snapshot/read-out request (ignored while streaming)
//   start_len   number of entries in the snapshot being captured
//   sel         snapshot slot whose data is wanted next
//   sel_data    data of slot sel, supplied by the buffer
//   idle        FSM is in IDLE (a request would be accepted)
//   rd          read-out stream, master side
module seq_readout
   import morse_pkg::*;
#(
   parameter int SEQ_W = SEQ_W_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enter,
   input  logic [$clog2(DEPTH+1)-1:0]   start_len,
   output logic [$clog2(DEPTH)-1:0]     sel,
   input  logic [SEQ_W-1:0]             sel_data,
   output logic                         idle,
   seq_store_buf_if.master              rd
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   rd_state_t       state_r;
   logic [PW-1:0]   idx_r;

   // Slot to fetch next: the oldest slot when starting, else one step newer.
   always_comb begin
      sel = idx_r;
      if (state_r == IDLE) begin
         sel = PW'(start_len - CW'(1));
      end else begin
         sel = idx_r - PW'(1);
      end
   end

   assign idle = (state_r == IDLE);

   // Read-out FSM with registered stream outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         idx_r       <= '0;
         rd.rd_valid <= 1'b0;
         rd.rd_last  <= 1'b0;
         rd.rd_data  <= '1;
      end else begin
         case (state_r)
            IDLE: begin
               if (enter && (start_len != CW'(0))) begin
                  state_r     <= STREAM;
                  idx_r       <= sel;
                  rd.rd_valid <= 1'b1;
                  rd.rd_data  <= sel_data;
                  rd.rd_last  <= (sel == PW'(0));
               end else begin
                  rd.rd_valid <= 1'b0;
                  rd.rd_last  <= 1'b0;
               end
            end
            STREAM: begin
               if (rd.rd_ready) begin
                  if (idx_r == PW'(0)) begin
                     state_r     <= IDLE;
                     rd.rd_valid <= 1'b0;
                     rd.rd_last  <= 1'b0;
                  end else begin
                     idx_r      <= sel;
                     rd.rd_data <= sel_data;
                     rd.rd_last <= (sel == PW'(0));
                  end
               end else begin
                  // Stalled: hold the presented entry.
                  idx_r <= idx_r;
               end
            end
            default: begin
               state_r     <= IDLE;
               rd.rd_valid <= 1'b0;
               rd.rd_last  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/seq_store_buf.sv
// Module: seq_store_buf
// Circular store for Morse sequence codes with an on-demand snapshot and an
// oldest-first read-out stream.
// Build option: define SEQ_STORE_RING_EN to overwrite the oldest entry when a
// write hits a full buffer; otherwise such writes are dropped. Either way the
// sticky overflow flag sets.
//   clk, reset           clock and asynchronous active-high reset
//   store                sample strobe for first_seq/sec_seq
//   first_seq, sec_seq   candidate codes (invalid when MSBs are 2'b11)
//   enter                snapshot + read-out request
//   o_sequence           snapshot, newest entry in the low slot, unused = ones
//   count, full          live entry count and full flag
//   overflow             sticky: a write found the buffer full
//   rd                   read-out stream (master side)
module seq_store_buf
   import morse_pkg::*;
#(
   parameter int SEQ_W = SEQ_W_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         store,
   input  logic [SEQ_W-1:0]             first_seq,
   input  logic [SEQ_W-1:0]             sec_seq,
   input  logic                         enter,
   output logic [DEPTH*SEQ_W-1:0]       o_sequence,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         overflow,
   seq_store_buf_if.master              rd
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [SEQ_W-1:0] mem_r      [DEPTH];
   logic [SEQ_W-1:0] snap_r     [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [CW-1:0]    count_r;
   logic             overflow_r;

   logic [SEQ_W-1:0] mem_nxt_s  [DEPTH];
   logic [SEQ_W-1:0] snap_nxt_s [DEPTH];
   logic [PW-1:0]    ptr_nxt_s;
   logic [CW-1:0]    count_nxt_s;
   logic [CW:0]      cnt_ext_s;
   logic [CW:0]      sum_s;
   logic             first_ok_s, sec_ok_s;
   logic             a_en_s, b_en_s, a_ok_s, b_ok_s;
   logic [SEQ_W-1:0] a_data_s;
   logic             ovf_set_s;
   logic             idle_s;
   logic             take_snap_s;
   logic [PW-1:0]    sel_s;
   logic [SEQ_W-1:0] sel_data_s;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? PW'(0) : p + PW'(1);
   endfunction

   // Write arbitration: lane a is the first valid lane, lane b the second.
   always_comb begin
      first_ok_s = tag_ok(first_seq[SEQ_W-1 -: 2]);
      sec_ok_s   = tag_ok(sec_seq[SEQ_W-1 -: 2]);
      a_en_s     = store && (first_ok_s || sec_ok_s);
      b_en_s     = store && first_ok_s && sec_ok_s;
      a_data_s   = first_ok_s ? first_seq : sec_seq;
      cnt_ext_s  = {1'b0, count_r};
`ifdef SEQ_STORE_RING_EN
      a_ok_s      = a_en_s;
      b_ok_s      = b_en_s;
      sum_s       = cnt_ext_s + (CW+1)'(a_ok_s) + (CW+1)'(b_ok_s);
      ovf_set_s   = (sum_s > (CW+1)'(DEPTH));
      count_nxt_s = ovf_set_s ? CW'(DEPTH) : CW'(sum_s);
`else
      a_ok_s      = a_en_s && (cnt_ext_s < (CW+1)'(DEPTH));
      b_ok_s      = b_en_s && ((cnt_ext_s + (CW+1)'(2)) <= (CW+1)'(DEPTH));
      sum_s       = cnt_ext_s + (CW+1)'(a_ok_s) + (CW+1)'(b_ok_s);
      ovf_set_s   = (a_en_s && !a_ok_s) || (b_en_s && !b_ok_s);
      count_nxt_s = CW'(sum_s);
`endif
   end

   // Next memory image: writes land at the write pointer, first lane first.
   // When full in ring mode the write pointer sits on the oldest slot.
   always_comb begin
      mem_nxt_s = mem_r;
      ptr_nxt_s = wr_ptr_r;
      if (a_ok_s) begin
         mem_nxt_s[ptr_nxt_s] = a_data_s;
         ptr_nxt_s            = ptr_inc(ptr_nxt_s);
      end else begin
         ptr_nxt_s = ptr_nxt_s;
      end
      if (b_ok_s) begin
         mem_nxt_s[ptr_nxt_s] = sec_seq;
         ptr_nxt_s            = ptr_inc(ptr_nxt_s);
      end else begin
         ptr_nxt_s = ptr_nxt_s;
      end
   end

   // Snapshot of the post-write state so same-cycle stores are included.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         snap_nxt_s[k] = (k < int'(count_nxt_s))
                       ? mem_nxt_s[PW'((int'(ptr_nxt_s) + DEPTH - 1 - k) % DEPTH)]
                       : '1;
      end
   end

   assign take_snap_s = enter && idle_s;
   assign sel_data_s  = take_snap_s ? snap_nxt_s[sel_s] : snap_r[sel_s];

   // Buffer, pointer, count, overflow and snapshot registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            mem_r[k]  <= '1;
            snap_r[k] <= '1;
         end
         wr_ptr_r   <= '0;
         count_r    <= '0;
         overflow_r <= 1'b0;
      end else begin
         mem_r    <= mem_nxt_s;
         wr_ptr_r <= ptr_nxt_s;
         count_r  <= count_nxt_s;
         if (ovf_set_s) begin
            overflow_r <= 1'b1;
         end else begin
            overflow_r <= overflow_r;
         end
         if (take_snap_s) begin
            snap_r <= snap_nxt_s;
         end else begin
            snap_r <= snap_r;
         end
      end
   end

   // Flatten the snapshot onto the output vector.
   always_comb begin
      o_sequence = '1;
      for (int k = 0; k < DEPTH; k++) begin
         o_sequence[k*SEQ_W +: SEQ_W] = snap_r[k];
      end
   end

   assign count    = count_r;
   assign full     = (count_r == CW'(DEPTH));
   assign overflow = overflow_r;

   seq_readout #(
      .SEQ_W (SEQ_W),
      .DEPTH (DEPTH)
   ) u_readout (
      .clk       (clk),
      .reset     (reset),
      .enter     (enter),
      .start_len (count_nxt_s),
      .sel       (sel_s),
      .sel_data  (sel_data_s),
      .idle      (idle_s),
      .rd        (rd)
   );

endmodule

// File: tb/tb_seq_store_buf.sv
// Bench for seq_store_buf (SEQ_W=10, DEPTH=16). The reference model is a
// queue of live entries (oldest at the front); snapshots and streams are
// derived from that queue.
module tb_seq_store_buf;

   localparam int SEQ_W = 10;
   localparam int DEPTH = 16;

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic                   store = 1'b0;
   logic [SEQ_W-1:0]       first_seq = '0;
   logic [SEQ_W-1:0]       sec_seq = '0;
   logic                   enter = 1'b0;
   logic [DEPTH*SEQ_W-1:0] o_sequence;
   logic [4:0]             count;
   logic                   full;
   logic                   overflow;

   int checks = 0;
   int errors = 0;

   logic [SEQ_W-1:0] q[$];
   logic             m_ovf;

   seq_store_buf_if #(.SEQ_W(SEQ_W)) rd_if ();

   seq_store_buf #(.SEQ_W(SEQ_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .store      (store),
      .first_seq  (first_seq),
      .sec_seq    (sec_seq),
      .enter      (enter),
      .o_sequence (o_sequence),
      .count      (count),
      .full       (full),
      .overflow   (overflow),
      .rd         (rd_if)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit lane_ok(input logic [SEQ_W-1:0] d);
      return d[SEQ_W-1:SEQ_W-2] != 2'b11;
   endfunction

   task automatic model_push(input logic [SEQ_W-1:0] d);
      if (q.size() < DEPTH) begin
         q.push_back(d);
      end else begin
`ifdef SEQ_STORE_RING_EN
         q.delete(0);
         q.push_back(d);
`endif
         m_ovf = 1'b1;
      end
   endtask

   function automatic logic [DEPTH*SEQ_W-1:0] model_snap();
      logic [DEPTH*SEQ_W-1:0] v;
      v = '1;
      for (int k = 0; k < q.size(); k++) v[k*SEQ_W +: SEQ_W] = q[q.size()-1-k];
      return v;
   endfunction

   task automatic do_store(input logic [SEQ_W-1:0] f, input logic [SEQ_W-1:0] s, input logic en);
      store = 1'b1; first_seq = f; sec_seq = s; enter = en;
      tick();
      store = 1'b0; enter = 1'b0;
      if (lane_ok(f)) model_push(f);
      if (lane_ok(s)) model_push(s);
   endtask

   task automatic do_reset();
      reset = 1'b1; store = 1'b0; enter = 1'b0; rd_if.rd_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
      q.delete();
      m_ovf = 1'b0;
   endtask

   task automatic drain();
      rd_if.rd_ready = 1'b1;
      repeat (20) tick();
      rd_if.rd_ready = 1'b0;
   endtask

   function automatic logic [SEQ_W-1:0] rand_valid();
      return SEQ_W'($urandom_range(0, 767));
   endfunction

   task automatic test_reset();
      do_reset();
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
      checks++; if (rd_if.rd_valid !== 1'b0 || rd_if.rd_last !== 1'b0) begin errors++; $display("FAIL reset_rd_flags got %b%b exp 00", rd_if.rd_valid, rd_if.rd_last); end
      checks++; if (rd_if.rd_data !== 10'h3FF) begin errors++; $display("FAIL reset_rd_data got %h exp 3ff", rd_if.rd_data); end
      checks++; if (o_sequence !== {DEPTH*SEQ_W{1'b1}}) begin errors++; $display("FAIL reset_o_sequence got %h", o_sequence); end
   endtask

   task automatic test_basic();
      do_reset();
      do_store(10'h001, 10'h002, 1'b0);
      enter = 1'b1; tick(); enter = 1'b0;
      checks++; if (count !== 5'd2) begin errors++; $display("FAIL basic_count got %0d exp 2", count); end
      checks++; if (o_sequence[19:0] !== {10'h001, 10'h002}) begin errors++; $display("FAIL basic_low got %h exp 00402", o_sequence[19:0]); end
      checks++; if (o_sequence[DEPTH*SEQ_W-1:20] !== {(DEPTH*SEQ_W-20){1'b1}}) begin errors++; $display("FAIL basic_upper got %h", o_sequence[DEPTH*SEQ_W-1:20]); end
      drain();
      checks++; if (rd_if.rd_valid !== 1'b0) begin errors++; $display("FAIL basic_drain rd_valid got %b exp 0", rd_if.rd_valid); end
   endtask

   task automatic test_invalid_lane();
      do_reset();
      do_store(10'h3FF, 10'h005, 1'b0);
      checks++; if (count !== 5'd1) begin errors++; $display("FAIL inval_count got %0d exp 1", count); end
      do_store(10'h300, 10'h3C1, 1'b0);
      checks++; if (count !== 5'd1) begin errors++; $display("FAIL inval_both_count got %0d exp 1", count); end
      do_store(10'h2FF, 10'h3FF, 1'b0);
      checks++; if (count !== 5'd2) begin errors++; $display("FAIL inval_msb10_count got %0d exp 2", count); end
      enter = 1'b1; tick(); enter = 1'b0;
      checks++; if (o_sequence[19:10] !== 10'h005) begin errors++; $display("FAIL inval_slot1 got %h exp 005", o_sequence[19:10]); end
      checks++; if (o_sequence !== model_snap()) begin errors++; $display("FAIL inval_snap got %h exp %h", o_sequence, model_snap()); end
      drain();
   endtask

   task automatic test_full();
      logic [SEQ_W-1:0] fill [15];
      logic [SEQ_W-1:0] a, b;
      do_reset();
      for (int i = 0; i < 15; i++) begin
         fill[i] = rand_valid();
         do_store(fill[i], 10'h3FF, 1'b0);
      end
      checks++; if (count !== 5'd15 || full !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL full_pre got cnt=%0d full=%b ovf=%b exp 15/0/0", count, full, overflow); end
      a = rand_valid(); b = rand_valid();
      do_store(a, b, 1'b0);
      checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_count got %0d exp 16", count); end
      checks++; if (full !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL full_flags got full=%b ovf=%b exp 1/1", full, overflow); end
      enter = 1'b1; tick(); enter = 1'b0;
      checks++; if (o_sequence !== model_snap()) begin errors++; $display("FAIL full_snap got %h exp %h", o_sequence, model_snap()); end
`ifdef SEQ_STORE_RING_EN
      checks++; if (o_sequence[9:0] !== b || o_sequence[19:10] !== a) begin errors++; $display("FAIL full_ring_newest got %h exp %h%h", o_sequence[19:0], a, b); end
      checks++; if (o_sequence[159:150] !== fill[1]) begin errors++; $display("FAIL full_ring_oldest got %h exp %h", o_sequence[159:150], fill[1]); end
`else
      checks++; if (o_sequence[9:0] !== a) begin errors++; $display("FAIL full_drop_newest got %h exp %h", o_sequence[9:0], a); end
      checks++; if (o_sequence[159:150] !== fill[0]) begin errors++; $display("FAIL full_drop_oldest got %h exp %h", o_sequence[159:150], fill[0]); end
`endif
      drain();
   endtask

   task automatic test_random();
      logic [SEQ_W-1:0] f, s;
      logic st;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         f = SEQ_W'($urandom_range(0, 1023));
         s = SEQ_W'($urandom_range(0, 1023));
         st = 1'($urandom_range(0, 1));
         store = st; first_seq = f; sec_seq = s;
         tick();
         store = 1'b0;
         if (st) begin
            if (lane_ok(f)) model_push(f);
            if (lane_ok(s)) model_push(s);
         end
         checks++; if (count !== 5'(q.size())) begin errors++; $display("FAIL rand_count i=%0d got %0d exp %0d", i, count, q.size()); end
         checks++; if (full !== (q.size() == DEPTH)) begin errors++; $display("FAIL rand_full i=%0d got %b", i, full); end
         checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand_overflow i=%0d got %b exp %b", i, overflow, m_ovf); end
      end
      enter = 1'b1; tick(); enter = 1'b0;
      checks++; if (o_sequence !== model_snap()) begin errors++; $display("FAIL rand_snap got %h exp %h", o_sequence, model_snap()); end
      drain();
   endtask

   task automatic test_stream();
      bit pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      int pos;
      do_reset();
      for (int i = 0; i < 3; i++) do_store(rand_valid(), 10'h3FF, 1'b0);
      enter = 1'b1; tick(); enter = 1'b0;
      pos = 0;
      for (int j = 0; j < 4; j++) begin
         checks++; if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== q[pos] || rd_if.rd_last !== (pos == 2)) begin
            errors++; $display("FAIL stream_beat j=%0d got v=%b d=%h l=%b exp 1/%h/%b", j, rd_if.rd_valid, rd_if.rd_data, rd_if.rd_last, q[pos], pos == 2);
         end
         rd_if.rd_ready = pat[j];
         tick();
         if (pat[j]) pos++;
      end
      rd_if.rd_ready = 1'b0;
      checks++; if (rd_if.rd_valid !== 1'b0 || rd_if.rd_last !== 1'b0) begin errors++; $display("FAIL stream_end got v=%b l=%b exp 0/0", rd_if.rd_valid, rd_if.rd_last); end
      checks++; if (pos != 3) begin errors++; $display("FAIL stream_transfers got %0d exp 3", pos); end
   endtask

   task automatic test_store_during_stream();
      logic [SEQ_W-1:0] exp_q[$];
      logic [DEPTH*SEQ_W-1:0] exp_snap;
      do_reset();
      for (int i = 0; i < 3; i++) do_store(rand_valid(), 10'h3FF, 1'b0);
      enter = 1'b1; tick(); enter = 1'b0;
      exp_q = q;
      exp_snap = model_snap();
      do_store(rand_valid(), rand_valid(), 1'b1);
      checks++; if (count !== 5'd5) begin errors++; $display("FAIL sds_count got %0d exp 5", count); end
      checks++; if (o_sequence !== exp_snap) begin errors++; $display("FAIL sds_snap got %h exp %h", o_sequence, exp_snap); end
      rd_if.rd_ready = 1'b1;
      for (int j = 0; j < 3; j++) begin
         checks++; if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== exp_q[j] || rd_if.rd_last !== (j == 2)) begin
            errors++; $display("FAIL sds_beat j=%0d got v=%b d=%h l=%b exp 1/%h/%b", j, rd_if.rd_valid, rd_if.rd_data, rd_if.rd_last, exp_q[j], j == 2);
         end
         tick();
      end
      repeat (3) tick();
      rd_if.rd_ready = 1'b0;
      checks++; if (rd_if.rd_valid !== 1'b0) begin errors++; $display("FAIL sds_no_restart rd_valid got %b exp 0", rd_if.rd_valid); end
   endtask

   task automatic test_enter_edge();
      logic [SEQ_W-1:0] a;
      do_reset();
      enter = 1'b1; tick(); enter = 1'b0;
      checks++; if (rd_if.rd_valid !== 1'b0) begin errors++; $display("FAIL empty_enter rd_valid got %b exp 0", rd_if.rd_valid); end
      checks++; if (o_sequence !== {DEPTH*SEQ_W{1'b1}}) begin errors++; $display("FAIL empty_enter o_sequence got %h", o_sequence); end
      a = rand_valid();
      do_store(a, 10'h3FF, 1'b1);
      checks++; if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== a || rd_if.rd_last !== 1'b1) begin
         errors++; $display("FAIL same_cycle_enter got v=%b d=%h l=%b exp 1/%h/1", rd_if.rd_valid, rd_if.rd_data, rd_if.rd_last, a);
      end
      checks++; if (o_sequence !== model_snap()) begin errors++; $display("FAIL same_cycle_snap got %h exp %h", o_sequence, model_snap()); end
      rd_if.rd_ready = 1'b1; tick(); rd_if.rd_ready = 1'b0;
      checks++; if (rd_if.rd_valid !== 1'b0) begin errors++; $display("FAIL single_last rd_valid got %b exp 0", rd_if.rd_valid); end
   endtask

   task automatic test_reset_mid_stream();
      do_reset();
      for (int i = 0; i < 3; i++) do_store(rand_valid(), 10'h3FF, 1'b0);
      enter = 1'b1; tick(); enter = 1'b0;
      checks++; if (rd_if.rd_valid !== 1'b1) begin errors++; $display("FAIL rms_pre rd_valid got %b exp 1", rd_if.rd_valid); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (rd_if.rd_valid !== 1'b0) begin errors++; $display("FAIL rms_async rd_valid got %b exp 0", rd_if.rd_valid); end
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL rms_count got %0d exp 0", count); end
      checks++; if (o_sequence !== {DEPTH*SEQ_W{1'b1}}) begin errors++; $display("FAIL rms_o_sequence got %h", o_sequence); end
      tick();
      reset = 1'b0;
      q.delete();
      m_ovf = 1'b0;
   endtask

   initial begin
      rd_if.rd_ready = 1'b0;
      m_ovf = 1'b0;
      test_reset();
      test_basic();
      test_invalid_lane();
      test_full();
      test_random();
      test_stream();
      test_store_during_stream();
      test_enter_edge();
      test_reset_mid_stream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
